// File: rtl/jpeg_bit_window.sv
// JPEG entropy-coded segment bit window.
// Strips 0xFF00 byte stuffing and 0xFF fill bytes, reports markers, and keeps a
// 64-bit left-aligned bit buffer from which a Huffman decoder takes 1..32 bits
// per cycle. Bits beyond the valid count read as 1 (JPEG fill).
module jpeg_bit_window (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        ByteInEnable,
    input  logic [7:0]  ByteIn,
    output logic        ByteInReady,
    input  logic        UseBit,
    input  logic [6:0]  UseWidth,
    output logic        DataOutEnable,
    output logic [31:0] DataOut,
    output logic [6:0]  BitCount,
    output logic        MarkerEnable,
    output logic [7:0]  MarkerCode,
    output logic        ScanEnd,
    output logic        Error
);

    typedef enum logic [1:0] {StIdle, StRun, StFfSeen, StHalt} state_t;

    state_t      state_q;
    logic [63:0] buf_q;
    logic [6:0]  cnt_q;
    logic        marker_en_q;
    logic [7:0]  marker_code_q;
    logic        scan_end_q;
    logic        error_q;

    logic        running;
    logic        accept;
    logic        width_ok;
    logic        consume;
    logic        bad_use;
    logic        over;
    logic [63:0] buf_shift;
    logic [6:0]  cnt_shift;
    logic        append;
    logic [7:0]  append_byte;
    logic        marker_hit;
    logic        marker_end;
    logic [63:0] buf_d;
    logic [6:0]  cnt_d;

    // Handshake, window validity and consume decode.
    always_comb begin
        running       = (state_q == StRun) || (state_q == StFfSeen);
        // Readiness looks at the registered count only, never the post-consume count.
        ByteInReady   = running && (cnt_q <= 7'd56) && !Start;
        accept        = ByteInEnable && ByteInReady;
        DataOutEnable = (cnt_q >= 7'd32) || ((state_q == StHalt) && (cnt_q != 7'd0));
        width_ok      = (UseWidth != 7'd0) && (UseWidth <= 7'd32);
        consume       = UseBit && DataOutEnable && width_ok;
        bad_use       = UseBit && !consume;
        // Only reachable in HALT, where the tail can be shorter than the request.
        over          = consume && (UseWidth > cnt_q);
    end

    // Shift out consumed bits first; an appended byte lands behind what remains.
    always_comb begin
        buf_shift = buf_q;
        cnt_shift = cnt_q;
        if (over) begin
            buf_shift = 64'd0;
            cnt_shift = 7'd0;
        end else if (consume) begin
            buf_shift = buf_q << UseWidth;
            cnt_shift = cnt_q - UseWidth;
        end
    end

    // Byte classification: what gets appended and whether a marker ends here.
    always_comb begin
        append      = 1'b0;
        append_byte = ByteIn;
        marker_hit  = 1'b0;
        marker_end  = 1'b0;
        if (accept) begin
            if (state_q == StRun) begin
                append = (ByteIn != 8'hFF);
            end else begin
                if (ByteIn == 8'h00) begin
                    append      = 1'b1;
                    append_byte = 8'hFF;
                end else if (ByteIn != 8'hFF) begin
                    marker_hit = 1'b1;
                    // RSTn markers (D0..D7) keep the scan going.
                    marker_end = (ByteIn[7:3] != 5'b11010);
                end
            end
        end
        buf_d = buf_shift;
        cnt_d = cnt_shift;
        if (append) begin
            // Accepting needs count <= 56, so the sum never passes 64.
            buf_d = buf_shift | ({append_byte, 56'd0} >> cnt_shift);
            cnt_d = cnt_shift + 7'd8;
        end
    end

    // State machine and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            buf_q         <= 64'd0;
            cnt_q         <= 7'd0;
            marker_en_q   <= 1'b0;
            marker_code_q <= 8'h00;
            scan_end_q    <= 1'b0;
            error_q       <= 1'b0;
        end else if (Start) begin
            state_q     <= StRun;
            buf_q       <= 64'd0;
            cnt_q       <= 7'd0;
            marker_en_q <= 1'b0;
            scan_end_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            marker_en_q <= marker_hit;
            if (marker_hit) begin
                marker_code_q <= ByteIn;
            end
            if (marker_end) begin
                scan_end_q <= 1'b1;
            end
            if (over || bad_use) begin
                error_q <= 1'b1;
            end
            if (accept) begin
                unique case (state_q)
                    StRun: begin
                        if (ByteIn == 8'hFF) begin
                            state_q <= StFfSeen;
                        end
                    end
                    StFfSeen: begin
                        if (marker_end) begin
                            state_q <= StHalt;
                        end else if (ByteIn != 8'hFF) begin
                            state_q <= StRun;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    // Unfilled positions in the visible word read as 1.
    always_comb begin
        DataOut      = buf_q[63:32] | (32'hFFFF_FFFF >> cnt_q);
        BitCount     = cnt_q;
        MarkerEnable = marker_en_q;
        MarkerCode   = marker_code_q;
        ScanEnd      = scan_end_q;
        Error        = error_q;
    end

endmodule

// File: tb/tb_jpeg_bit_window.sv
// Directed bench for jpeg_bit_window: inputs change on the falling edge,
// outputs are sampled #1 after an edge.
module tb_jpeg_bit_window;

    logic        clk;
    logic        rst;
    logic        Start;
    logic        ByteInEnable;
    logic [7:0]  ByteIn;
    logic        ByteInReady;
    logic        UseBit;
    logic [6:0]  UseWidth;
    logic        DataOutEnable;
    logic [31:0] DataOut;
    logic [6:0]  BitCount;
    logic        MarkerEnable;
    logic [7:0]  MarkerCode;
    logic        ScanEnd;
    logic        Error;

    int passed;
    int total;

    jpeg_bit_window dut (
        .clk          (clk),
        .rst          (rst),
        .Start        (Start),
        .ByteInEnable (ByteInEnable),
        .ByteIn       (ByteIn),
        .ByteInReady  (ByteInReady),
        .UseBit       (UseBit),
        .UseWidth     (UseWidth),
        .DataOutEnable(DataOutEnable),
        .DataOut      (DataOut),
        .BitCount     (BitCount),
        .MarkerEnable (MarkerEnable),
        .MarkerCode   (MarkerCode),
        .ScanEnd      (ScanEnd),
        .Error        (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ByteInEnable = 1'b1;
        ByteIn       = b;
        @(posedge clk);
        #1;
        ByteInEnable = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic do_use(input logic [6:0] w);
        @(negedge clk);
        UseBit   = 1'b1;
        UseWidth = w;
        @(posedge clk);
        #1;
        UseBit = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ByteInReady !== 1'b0) $display("FAIL reset_ready got %b exp 0", ByteInReady); else passed++;
        total++; if (DataOutEnable !== 1'b0) $display("FAIL reset_doe got %b exp 0", DataOutEnable); else passed++;
        total++; if (DataOut !== 32'hFFFF_FFFF) $display("FAIL reset_dataout got %h exp ffffffff", DataOut); else passed++;
        total++; if (BitCount !== 7'd0) $display("FAIL reset_count got %0d exp 0", BitCount); else passed++;
        total++; if ({MarkerEnable, MarkerCode, ScanEnd, Error} !== 11'd0)
            $display("FAIL reset_flags got me=%b mc=%h se=%b err=%b exp all 0", MarkerEnable, MarkerCode, ScanEnd, Error);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // (a) four plain bytes fill the window
    task automatic test_fill();
        do_start();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        total++; if (DataOutEnable !== 1'b0) $display("FAIL a_doe_24 got %b exp 0", DataOutEnable); else passed++;
        send_byte(8'h78);
        total++; if (DataOutEnable !== 1'b1) $display("FAIL a_doe got %b exp 1", DataOutEnable); else passed++;
        total++; if (DataOut !== 32'h1234_5678) $display("FAIL a_dataout got %h exp 12345678", DataOut); else passed++;
        total++; if (BitCount !== 7'd32) $display("FAIL a_count got %0d exp 32", BitCount); else passed++;
    endtask

    // (b) consume 4 bits, fill shows as F
    task automatic test_consume();
        do_use(7'd4);
        total++; if (DataOut !== 32'h2345_678F) $display("FAIL b_dataout got %h exp 2345678f", DataOut); else passed++;
        total++; if (BitCount !== 7'd28) $display("FAIL b_count got %0d exp 28", BitCount); else passed++;
        total++; if (DataOutEnable !== 1'b0) $display("FAIL b_doe got %b exp 0", DataOutEnable); else passed++;
        total++; if (Error !== 1'b0) $display("FAIL b_error got %b exp 0", Error); else passed++;
    endtask

    // (c) stuffing, fill bytes and an RST marker
    task automatic test_escape_marker();
        @(negedge clk);
        Start        = 1'b1;
        ByteInEnable = 1'b1;
        ByteIn       = 8'h55;
        #1;
        total++; if (ByteInReady !== 1'b0) $display("FAIL c_ready_start got %b exp 0", ByteInReady); else passed++;
        @(posedge clk);
        #1;
        Start        = 1'b0;
        ByteInEnable = 1'b0;
        total++; if (BitCount !== 7'd0) $display("FAIL c_count_start got %0d exp 0", BitCount); else passed++;
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        total++; if (DataOut !== 32'hFFAB_CDEF) $display("FAIL c_dataout got %h exp ffabcdef", DataOut); else passed++;
        total++; if (BitCount !== 7'd32) $display("FAIL c_count got %0d exp 32", BitCount); else passed++;
        send_byte(8'hFF);
        total++; if (MarkerEnable !== 1'b0) $display("FAIL c_me_early got %b exp 0", MarkerEnable); else passed++;
        send_byte(8'hFF);
        total++; if (MarkerEnable !== 1'b0) $display("FAIL c_me_fill got %b exp 0", MarkerEnable); else passed++;
        send_byte(8'hD3);
        total++; if (MarkerEnable !== 1'b1) $display("FAIL c_me got %b exp 1", MarkerEnable); else passed++;
        total++; if (MarkerCode !== 8'hD3) $display("FAIL c_mc got %h exp d3", MarkerCode); else passed++;
        total++; if (BitCount !== 7'd32) $display("FAIL c_count_marker got %0d exp 32", BitCount); else passed++;
        total++; if (ScanEnd !== 1'b0) $display("FAIL c_scanend got %b exp 0", ScanEnd); else passed++;
        @(posedge clk);
        #1;
        total++; if (MarkerEnable !== 1'b0) $display("FAIL c_me_pulse got %b exp 0", MarkerEnable); else passed++;
        send_byte(8'h12);
        total++; if (BitCount !== 7'd40) $display("FAIL c_count_run got %0d exp 40", BitCount); else passed++;
    endtask

    // (d) full buffer, then consume and append back to back
    task automatic test_back_to_back();
        do_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        total++; if (BitCount !== 7'd64) $display("FAIL d_count_full got %0d exp 64", BitCount); else passed++;
        @(negedge clk);
        ByteInEnable = 1'b1;
        ByteIn       = 8'h99;
        UseBit       = 1'b1;
        UseWidth     = 7'd8;
        #1;
        total++; if (ByteInReady !== 1'b0) $display("FAIL d_ready_full got %b exp 0", ByteInReady); else passed++;
        @(negedge clk);
        UseBit = 1'b0;
        #1;
        total++; if (BitCount !== 7'd56) $display("FAIL d_count_56 got %0d exp 56", BitCount); else passed++;
        total++; if (ByteInReady !== 1'b1) $display("FAIL d_ready got %b exp 1", ByteInReady); else passed++;
        @(negedge clk);
        ByteInEnable = 1'b0;
        #1;
        total++; if (BitCount !== 7'd64) $display("FAIL d_count got %0d exp 64", BitCount); else passed++;
        total++; if (DataOut !== 32'h2233_4455) $display("FAIL d_dataout got %h exp 22334455", DataOut); else passed++;
        total++; if (Error !== 1'b0) $display("FAIL d_error got %b exp 0", Error); else passed++;
        do_use(7'd32);
        do_use(7'd32);
        total++; if (DataOut !== 32'hFFFF_FFFF) $display("FAIL d_drain got %h exp ffffffff", DataOut); else passed++;
        do_use(7'd4);
        total++; if (Error !== 1'b1) $display("FAIL d_use_empty got %b exp 1", Error); else passed++;
    endtask

    // (e) end-of-scan marker, halt and over-consume
    task automatic test_scan_end();
        do_start();
        total++; if (Error !== 1'b0) $display("FAIL e_error_clear got %b exp 0", Error); else passed++;
        send_byte(8'hA5);
        send_byte(8'hFF);
        send_byte(8'hD9);
        total++; if (ScanEnd !== 1'b1) $display("FAIL e_scanend got %b exp 1", ScanEnd); else passed++;
        total++; if (MarkerCode !== 8'hD9) $display("FAIL e_mc got %h exp d9", MarkerCode); else passed++;
        total++; if (ByteInReady !== 1'b0) $display("FAIL e_ready got %b exp 0", ByteInReady); else passed++;
        total++; if (DataOutEnable !== 1'b1) $display("FAIL e_doe got %b exp 1", DataOutEnable); else passed++;
        total++; if (DataOut !== 32'hA5FF_FFFF) $display("FAIL e_dataout got %h exp a5ffffff", DataOut); else passed++;
        do_use(7'd12);
        total++; if (BitCount !== 7'd0) $display("FAIL e_count got %0d exp 0", BitCount); else passed++;
        total++; if (Error !== 1'b1) $display("FAIL e_error got %b exp 1", Error); else passed++;
        total++; if (DataOutEnable !== 1'b0) $display("FAIL e_doe_empty got %b exp 0", DataOutEnable); else passed++;
    endtask

    // (f) reset while in FF_SEEN overrides Start and a stuffed zero
    task automatic test_reset_ff_seen();
        do_start();
        send_byte(8'h12);
        send_byte(8'hFF);
        @(negedge clk);
        rst          = 1'b1;
        Start        = 1'b1;
        ByteInEnable = 1'b1;
        ByteIn       = 8'h00;
        @(posedge clk);
        #1;
        total++; if (BitCount !== 7'd0) $display("FAIL f_count got %0d exp 0", BitCount); else passed++;
        total++; if (DataOut !== 32'hFFFF_FFFF) $display("FAIL f_dataout got %h exp ffffffff", DataOut); else passed++;
        total++; if (DataOutEnable !== 1'b0) $display("FAIL f_doe got %b exp 0", DataOutEnable); else passed++;
        total++; if ({MarkerEnable, MarkerCode, ScanEnd, Error} !== 11'd0)
            $display("FAIL f_flags got me=%b mc=%h se=%b err=%b exp all 0", MarkerEnable, MarkerCode, ScanEnd, Error);
        else passed++;
        @(negedge clk);
        rst   = 1'b0;
        Start = 1'b0;
        #1;
        total++; if (ByteInReady !== 1'b0) $display("FAIL f_ready got %b exp 0", ByteInReady); else passed++;
        @(posedge clk);
        #1;
        total++; if (BitCount !== 7'd0) $display("FAIL f_ignored got %0d exp 0", BitCount); else passed++;
        @(negedge clk);
        ByteInEnable = 1'b0;
    endtask

    // Zero and oversized widths are rejected even with a valid window.
    task automatic test_bad_width();
        do_start();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        do_use(7'd0);
        total++; if (Error !== 1'b1) $display("FAIL g_width0 got %b exp 1", Error); else passed++;
        total++; if (BitCount !== 7'd32) $display("FAIL g_count0 got %0d exp 32", BitCount); else passed++;
        do_start();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        do_use(7'd33);
        total++; if (Error !== 1'b1) $display("FAIL g_width33 got %b exp 1", Error); else passed++;
        total++; if (DataOut !== 32'h0102_0304) $display("FAIL g_dataout got %h exp 01020304", DataOut); else passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        rst          = 1'b0;
        Start        = 1'b0;
        ByteInEnable = 1'b0;
        ByteIn       = 8'h00;
        UseBit       = 1'b0;
        UseWidth     = 7'd0;
        test_reset();
        test_fill();
        test_consume();
        test_escape_marker();
        test_back_to_back();
        test_scan_end();
        test_reset_ff_seen();
        test_bad_width();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_window.md
JPEG_BIT_WINDOW -- requirements
Module: jpeg_bit_window

Interface
REQ-001 The block SHALL use one clock `clk`; `rst` SHALL be a synchronous, active-high reset.
REQ-002 Ports SHALL be as follows (clock and reset first):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Start  in  1  one-cycle pulse; begin new scan
- ByteInEnable  in  1  byte valid
- ByteIn  in  8  entropy-coded byte
- ByteInReady  out  1  byte accepted when ByteInEnable=1
- UseBit  in  1  consume request from Huffman decoder
- UseWidth  in  7  bits to consume (1..32)
- DataOutEnable  out  1  window valid
- DataOut  out  32  MSB-first bit window
- BitCount  out  7  valid bits held (0..64)
- MarkerEnable  out  1  one-cycle pulse on marker
- MarkerCode  out  8  second byte of last marker
- ScanEnd  out  1  non-RST marker seen; input halted
- Error  out  1  sticky protocol error

Function
REQ-003 Storage SHALL be a 64-bit left-aligned buffer plus a 7-bit count.
- DataOut = buffer[63:32].
- Bits beyond count read as 1 (JPEG fill).
REQ-004 The state machine SHALL have four states:
- IDLE (reset state)
- RUN
- FF_SEEN
- HALT
REQ-005 Start in any state SHALL clear the buffer, count, ScanEnd and Error, and SHALL enter RUN next cycle; a byte presented in the Start cycle SHALL be dropped.
REQ-006 ByteInReady SHALL be 1 only in RUN/FF_SEEN with count<=56 (post-consume count not used); it SHALL be 0 in IDLE, HALT and the Start cycle.
REQ-007 An accepted byte in RUN SHALL behave as follows:
- Non-0xFF: append at bit position count.
- 0xFF: do not append; go to FF_SEEN.
REQ-008 An accepted byte in FF_SEEN SHALL behave as follows:
- 0x00: append 0xFF; go to RUN.
- 0xFF: fill byte; stay in FF_SEEN; nothing appended.
- 0xD0-0xD7: pulse MarkerEnable; MarkerCode=byte; go to RUN.
- Any other value: pulse MarkerEnable; MarkerCode=byte; set ScanEnd; go to HALT.
REQ-009 DataOutEnable SHALL be combinational: count>=32, or (HALT and count>0).
REQ-010 UseBit with DataOutEnable=1 and UseWidth in 1..32 SHALL shift the buffer left by UseWidth and decrement count; the new DataOut SHALL be visible the next cycle.
REQ-011 If UseWidth exceeds count (possible in HALT), count SHALL become 0 and Error SHALL set.
REQ-012 UseBit with DataOutEnable=0, UseWidth=0, or UseWidth>32 SHALL be ignored and SHALL set Error.
REQ-013 A consume and an append in the same cycle SHALL both apply: shift first, then place the byte at (count-UseWidth).
- count_next = count - UseWidth + 8.
- count SHALL never exceed 64.
REQ-014 In HALT, consumes SHALL continue until count=0; the block SHALL stay in HALT until Start.
REQ-015 BitCount SHALL equal the registered count.

Reset
REQ-016 On rst=1 at a clk edge, the block SHALL reset as follows:
- state=IDLE
- buffer=0, count=0
- ByteInReady=0, DataOutEnable=0
- MarkerEnable=0, MarkerCode=0x00
- ScanEnd=0, Error=0
- DataOut=0xFFFFFFFF (count=0, all fill)
REQ-017 rst SHALL override Start and all inputs in the same cycle, including mid-scan and in FF_SEEN.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- (a) Start; bytes 12 34 56 78 -> DataOutEnable=1, DataOut=0x12345678, BitCount=32.
- (b) Then UseBit, UseWidth=4 -> next cycle DataOut=0x2345678F, BitCount=28, DataOutEnable=0.
- (c) Bytes FF 00 AB CD EF -> DataOut=0xFFABCDEF; FF FF D3 mid-stream -> single MarkerEnable pulse, MarkerCode=0xD3, no bits added.
- (d) Bytes 11 22 33 44 55 66 77 88 -> ByteInReady=0 at count=64; byte 99 offered with UseWidth=8 consume in the same cycle -> ByteInReady=1, byte 99 accepted, BitCount=64, DataOut=0x22334455.
- (e) Bytes A5 FF D9 -> ScanEnd=1, MarkerCode=0xD9, ByteInReady=0, DataOutEnable=1, DataOut=0xA5FFFFFF; UseWidth=12 -> BitCount=0, Error=1.
- (f) rst during FF_SEEN -> all outputs at reset values; following 0x00 byte ignored until Start.
